// File: rtl/pzcorebus_pkg.sv
// Shared helpers for the pzcorebus blocks: width ratios and byte-enable widths.
package pzcorebus_pkg;

  // Number of narrow slices that make up one wide data word.
  function automatic int calc_ratio(input int slave_width, input int master_width);
    return slave_width / master_width;
  endfunction

  // One byte enable per eight data bits.
  function automatic int calc_byteen_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/pzcorebus_downsizer_write_data_path.sv
// Write-data path of the pzcorebus downsizer: splits each wide write-data beat
// into narrow beats, skipping slices whose byte enables are all zero.
module pzcorebus_downsizer_write_data_path
  import pzcorebus_pkg::*;
#(
  parameter int SLAVE_DATA_WIDTH    = 128,
  parameter int MASTER_DATA_WIDTH   = 32,
  parameter int ALIGNED_ACCESS_ONLY = 0
)(
  input  logic                                             i_clk,
  input  logic                                             i_rst_n,
  input  logic                                             i_mdata_valid,
  output logic                                             o_mdata_accept,
  input  logic [SLAVE_DATA_WIDTH-1:0]                      i_mdata,
  input  logic [calc_byteen_width(SLAVE_DATA_WIDTH)-1:0]   i_mdata_byteen,
  input  logic                                             i_mdata_last,
  output logic                                             o_mdata_valid,
  input  logic                                             i_mdata_accept,
  output logic [MASTER_DATA_WIDTH-1:0]                     o_mdata,
  output logic [calc_byteen_width(MASTER_DATA_WIDTH)-1:0]  o_mdata_byteen,
  output logic                                             o_mdata_last
);

  localparam int RATIO = calc_ratio(SLAVE_DATA_WIDTH, MASTER_DATA_WIDTH);
  localparam int SBE   = calc_byteen_width(SLAVE_DATA_WIDTH);
  localparam int MBE   = calc_byteen_width(MASTER_DATA_WIDTH);
  localparam int IDXW  = (RATIO > 1) ? $clog2(RATIO) : 1;

  // A slice is pending when any of its bytes is enabled. A beat with no
  // enabled bytes still produces one narrow beat (the top slice) so that the
  // beat count and the last flag reach the master side.
  function automatic logic [RATIO-1:0] calc_slice_mask(input logic [SBE-1:0] be);
    logic [RATIO-1:0] m;
    for (int i = 0; i < RATIO; i++) begin
      m[i] = |be[i*MBE +: MBE];
    end
    if (ALIGNED_ACCESS_ONLY != 0) begin
      m = '1;
    end else if (m == '0) begin
      m[RATIO-1] = 1'b1;
    end
    return m;
  endfunction

  // Index of the lowest set bit; slices go out from low to high address.
  function automatic logic [IDXW-1:0] lowest_set_bit(input logic [RATIO-1:0] m);
    logic [IDXW-1:0] idx;
    idx = '0;
    for (int i = RATIO - 1; i >= 0; i--) begin
      if (m[i]) begin
        idx = IDXW'(i);
      end
    end
    return idx;
  endfunction

  logic                        hold_valid_q, hold_valid_d;
  logic [RATIO-1:0]            pending_q, pending_d;
  logic                        last_q, last_d;
  logic [SLAVE_DATA_WIDTH-1:0] data_q;
  logic [SBE-1:0]              byteen_q;

  logic [IDXW-1:0] sel_idx;
  logic            one_left;
  logic            narrow_xfer;
  logic            wide_xfer;

  // Slice selection and handshakes; a new wide beat is taken in the same
  // cycle the final slice of the current one leaves, so there is no bubble.
  always_comb begin
    sel_idx        = lowest_set_bit(pending_q);
    one_left       = (pending_q != '0) && ((pending_q & (pending_q - RATIO'(1))) == '0);
    narrow_xfer    = hold_valid_q && i_mdata_accept;
    o_mdata_accept = !hold_valid_q || (i_mdata_accept && one_left);
    wide_xfer      = i_mdata_valid && o_mdata_accept;
    o_mdata_valid  = hold_valid_q;
    o_mdata        = data_q[sel_idx*MASTER_DATA_WIDTH +: MASTER_DATA_WIDTH];
    o_mdata_byteen = byteen_q[sel_idx*MBE +: MBE];
    o_mdata_last   = last_q && one_left;
  end

  // Next control state: reload on a wide transfer, otherwise retire the
  // selected slice and drop hold_valid once the final slice is gone.
  always_comb begin
    hold_valid_d = hold_valid_q;
    pending_d    = pending_q;
    last_d       = last_q;
    if (wide_xfer) begin
      hold_valid_d = 1'b1;
      pending_d    = calc_slice_mask(i_mdata_byteen);
      last_d       = i_mdata_last;
    end else if (narrow_xfer) begin
      pending_d = pending_q & ~(RATIO'(1) << sel_idx);
      if (one_left) begin
        hold_valid_d = 1'b0;
      end
    end
  end

  // Control state is reset so a beat interrupted by reset is discarded.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_valid_q <= 1'b0;
      pending_q    <= '0;
      last_q       <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      pending_q    <= pending_d;
      last_q       <= last_d;
    end
  end

  // Payload holding registers only matter while hold_valid is set.
  always_ff @(posedge i_clk) begin
    if (wide_xfer) begin
      data_q   <= i_mdata;
      byteen_q <= i_mdata_byteen;
    end
  end

endmodule

// File: tb/tb_pzcorebus_downsizer_write_data_path.sv
// Testbench for pzcorebus_downsizer_write_data_path (128 -> 32 bits).
module tb_pzcorebus_downsizer_write_data_path;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  be;
    logic        last;
    logic        isFinal;
  } beat_t;

  logic         clk = 1'b0;
  logic         rstN;
  logic         wideValid;
  logic         wideValidAl;
  logic [127:0] wideData;
  logic [15:0]  wideBe;
  logic         wideLast;
  logic         narrowAccept;
  logic         narrowAcceptAl;

  logic         oAccept, oValid, oLast;
  logic [31:0]  oData;
  logic [3:0]   oBe;
  logic         oAcceptAl, oValidAl, oLastAl;
  logic [31:0]  oDataAl;
  logic [3:0]   oBeAl;

  int errors = 0;
  int checks = 0;
  beat_t sbQ[$];

  logic        prevHeld = 1'b0;
  logic [31:0] heldData;
  logic [3:0]  heldBe;
  logic        heldLast;

  pzcorebus_downsizer_write_data_path #(
    .SLAVE_DATA_WIDTH(128), .MASTER_DATA_WIDTH(32), .ALIGNED_ACCESS_ONLY(0)
  ) dut (
    .i_clk(clk), .i_rst_n(rstN),
    .i_mdata_valid(wideValid), .o_mdata_accept(oAccept),
    .i_mdata(wideData), .i_mdata_byteen(wideBe), .i_mdata_last(wideLast),
    .o_mdata_valid(oValid), .i_mdata_accept(narrowAccept),
    .o_mdata(oData), .o_mdata_byteen(oBe), .o_mdata_last(oLast)
  );

  pzcorebus_downsizer_write_data_path #(
    .SLAVE_DATA_WIDTH(128), .MASTER_DATA_WIDTH(32), .ALIGNED_ACCESS_ONLY(1)
  ) dutAl (
    .i_clk(clk), .i_rst_n(rstN),
    .i_mdata_valid(wideValidAl), .o_mdata_accept(oAcceptAl),
    .i_mdata(wideData), .i_mdata_byteen(wideBe), .i_mdata_last(wideLast),
    .o_mdata_valid(oValidAl), .i_mdata_accept(narrowAcceptAl),
    .o_mdata(oDataAl), .o_mdata_byteen(oBeAl), .o_mdata_last(oLastAl)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: compare each narrow beat, the wide-side accept, and
  // stability of a stalled beat, sampled on the falling edge.
  always @(negedge clk) begin
    if (rstN) begin
      if (prevHeld) begin
        checks++;
        if (oValid !== 1'b1 || oData !== heldData || oBe !== heldBe || oLast !== heldLast) begin
          errors++;
          $display("[TB] FAIL hold_stable: got v=%b d=%h be=%h l=%b, required v=1 d=%h be=%h l=%b",
                   oValid, oData, oBe, oLast, heldData, heldBe, heldLast);
        end
      end
      if (oValid === 1'b1) begin
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got d=%h be=%h, required no beat", oData, oBe);
        end else begin
          beat_t exp;
          exp = sbQ[0];
          checks++;
          if (oData !== exp.data || oBe !== exp.be || oLast !== exp.last) begin
            errors++;
            $display("[TB] FAIL narrow_beat: got d=%h be=%h l=%b, required d=%h be=%h l=%b",
                     oData, oBe, oLast, exp.data, exp.be, exp.last);
          end
          checks++;
          if (oAccept !== (narrowAccept && exp.isFinal)) begin
            errors++;
            $display("[TB] FAIL wide_accept_busy: got %b, required %b",
                     oAccept, narrowAccept && exp.isFinal);
          end
          if (narrowAccept) void'(sbQ.pop_front());
        end
      end else begin
        checks++;
        if (oAccept !== 1'b1) begin
          errors++;
          $display("[TB] FAIL wide_accept_idle: got %b, required 1", oAccept);
        end
      end
      prevHeld = oValid && !narrowAccept;
      heldData = oData;
      heldBe   = oBe;
      heldLast = oLast;
    end else begin
      prevHeld = 1'b0;
    end
  end

  // Reference model: push the narrow beats a wide beat is expected to produce.
  task automatic push_expected(input logic [127:0] d, input logic [15:0] be, input logic last);
    int idx[$];
    for (int i = 0; i < 4; i++) begin
      if (be[i*4 +: 4] != 4'h0) idx.push_back(i);
    end
    if (idx.size() == 0) idx.push_back(3);
    foreach (idx[k]) begin
      beat_t b;
      b.data    = d[idx[k]*32 +: 32];
      b.be      = be[idx[k]*4 +: 4];
      b.isFinal = (k == idx.size() - 1);
      b.last    = last && b.isFinal;
      sbQ.push_back(b);
    end
  endtask

  // Present one wide beat and hold it until the main DUT takes it.
  task automatic drive_wide(input logic [127:0] d, input logic [15:0] be, input logic last);
    int budget = 0;
    logic wasIdle;
    wideValid = 1'b1;
    wideData  = d;
    wideBe    = be;
    wideLast  = last;
    push_expected(d, be, last);
    forever begin
      @(negedge clk);
      if (oAccept === 1'b1) break;
      budget++;
      if (budget > 100) begin
        errors++;
        $display("[TB] FAIL wide_accept_timeout: got accept=0 for 100 cycles, required 1");
        break;
      end
    end
    wasIdle = !oValid;
    @(posedge clk);
    #1;
    wideValid = 1'b0;
    if (wasIdle) begin
      checks++;
      if (oValid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL valid_latency: got %b one cycle after wide transfer, required 1", oValid);
      end
    end
  endtask

  // Wait for all expected beats to drain and the output to go idle.
  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sbQ.size() == 0) break;
    end
    @(posedge clk);
    #1;
    checks++;
    if (sbQ.size() != 0 || oValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending, valid=%b, required 0 pending, valid=0", sbQ.size(), oValid);
    end
    sbQ.delete();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (oValid !== 1'b0 || oLast !== 1'b0 || oAccept !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got v=%b l=%b a=%b, required v=0 l=0 a=1", oValid, oLast, oAccept);
    end
    checks++;
    if (oValidAl !== 1'b0 || oAcceptAl !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_outputs_aligned: got v=%b a=%b, required v=0 a=1", oValidAl, oAcceptAl);
    end
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  task automatic test_full_beat();
    drive_wide({32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000}, 16'hFFFF, 1'b1);
    wait_drain();
  endtask

  task automatic test_sparse();
    drive_wide({32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 16'h0F00, 1'b0);
    wait_drain();
    drive_wide({32'h8888_8888, 32'h7777_7777, 32'h6666_6666, 32'h5555_5555}, 16'h0000, 1'b1);
    wait_drain();
    drive_wide({32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000}, 16'h8010, 1'b1);
    wait_drain();
    drive_wide({32'h0BAD_0003, 32'h0BAD_0002, 32'h0BAD_0001, 32'h0BAD_0000}, 16'h0302, 1'b0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic done = 1'b0;
    fork
      begin
        drive_wide({32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0}, 16'hFFFF, 1'b0);
        drive_wide({32'hB3B3_B3B3, 32'hB2B2_B2B2, 32'hB1B1_B1B1, 32'hB0B0_B0B0}, 16'hFFFF, 1'b1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          narrowAccept = ~narrowAccept;
        end
      end
    join
    wait_drain();
    narrowAccept = 1'b1;
  endtask

  task automatic test_random();
    logic done = 1'b0;
    fork
      begin
        for (int n = 0; n < 12; n++) begin
          logic [127:0] d;
          logic [15:0] be;
          d  = {$urandom, $urandom, $urandom, $urandom};
          be = 16'($urandom);
          if (n % 4 == 0) be = 16'h0000;
          drive_wide(d, be, 1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          narrowAccept = 1'($urandom_range(0, 1));
        end
      end
    join
    narrowAccept = 1'b1;
    wait_drain();
  endtask

  task automatic test_aligned();
    logic [31:0] expData[4];
    logic [3:0]  expBe[4];
    int budget;
    expData = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
    expBe   = '{4'h0, 4'h0, 4'hF, 4'h0};
    wideData    = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    wideBe      = 16'h0F00;
    wideLast    = 1'b1;
    wideValidAl = 1'b1;
    @(posedge clk);
    #1;
    wideValidAl = 1'b0;
    for (int k = 0; k < 4; k++) begin
      budget = 0;
      @(negedge clk);
      while (oValidAl !== 1'b1 && budget < 20) begin
        budget++;
        @(negedge clk);
      end
      checks++;
      if (oValidAl !== 1'b1 || oDataAl !== expData[k] || oBeAl !== expBe[k] || oLastAl !== (k == 3)) begin
        errors++;
        $display("[TB] FAIL aligned_beat%0d: got v=%b d=%h be=%h l=%b, required v=1 d=%h be=%h l=%b",
                 k, oValidAl, oDataAl, oBeAl, oLastAl, expData[k], expBe[k], k == 3);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (oValidAl !== 1'b0) begin
      errors++;
      $display("[TB] FAIL aligned_idle: got valid=%b, required 0", oValidAl);
    end
  endtask

  task automatic test_reset_mid_beat();
    drive_wide({32'hF3F3_F3F3, 32'hF2F2_F2F2, 32'hF1F1_F1F1, 32'hF0F0_F0F0}, 16'hFFFF, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #3;
    rstN = 1'b0;
    #1;
    checks++;
    if (oValid !== 1'b0 || oLast !== 1'b0 || oAccept !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_beat: got v=%b l=%b a=%b, required v=0 l=0 a=1", oValid, oLast, oAccept);
    end
    checks++;
    if (sbQ.size() != 2) begin
      errors++;
      $display("[TB] FAIL beats_before_reset: got %0d left, required 2", sbQ.size());
    end
    sbQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;
    drive_wide({32'hE3E3_E3E3, 32'hE2E2_E2E2, 32'hE1E1_E1E1, 32'hE0E0_E0E0}, 16'hFFFF, 1'b0);
    wait_drain();
  endtask

  initial begin
    rstN           = 1'b0;
    wideValid      = 1'b0;
    wideValidAl    = 1'b0;
    wideData       = '0;
    wideBe         = '0;
    wideLast       = 1'b0;
    narrowAccept   = 1'b1;
    narrowAcceptAl = 1'b1;
    test_reset();
    test_full_beat();
    test_sparse();
    test_back_to_back();
    test_aligned();
    test_random();
    test_reset_mid_beat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pzcorebus_downsizer_write_data_path.md
PZCOREBUS_DOWNSIZER_WRITE_DATA_PATH -- requirements
Module: pzcorebus_downsizer_write_data_path

Interface
REQ-001 SHALL have parameter SLAVE_DATA_WIDTH, default 128: wide (slave-side) write-data width in bits.
REQ-002 SHALL have parameter MASTER_DATA_WIDTH, default 32: narrow (master-side) write-data width in bits.
REQ-003 SHALL have parameter ALIGNED_ACCESS_ONLY, default 0: when 1, every slice is emitted regardless of byte enable.
REQ-004 SHALL derive RATIO = SLAVE_DATA_WIDTH/MASTER_DATA_WIDTH (power of two, >=2); byte-enable widths = data width/8.
REQ-005 i_clk  input  1  clock.
REQ-006 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 i_mdata_valid  input  1  wide write-data beat valid.
REQ-008 o_mdata_accept  output  1  wide beat accepted.
REQ-009 i_mdata  input  SLAVE_DATA_WIDTH  wide write data.
REQ-010 i_mdata_byteen  input  SLAVE_DATA_WIDTH/8  wide byte enables.
REQ-011 i_mdata_last  input  1  last wide beat of burst.
REQ-012 o_mdata_valid  output  1  narrow beat valid.
REQ-013 i_mdata_accept  input  1  narrow beat accepted.
REQ-014 o_mdata  output  MASTER_DATA_WIDTH  narrow write data.
REQ-015 o_mdata_byteen  output  MASTER_DATA_WIDTH/8  narrow byte enables.
REQ-016 o_mdata_last  output  1  last narrow beat of burst.

Function
REQ-017 Transfer occurs on a side when valid and accept are both high in the same cycle.
REQ-018 Block SHALL hold one wide beat in a holding register (data, byteen, last) plus a RATIO-bit pending mask and a hold_valid flag.
REQ-019 On wide transfer, pending mask bit i SHALL load |byteen[slice i]; all ones if ALIGNED_ACCESS_ONLY=1; if computed mask is zero, load only bit RATIO-1 (one beat always emitted).
REQ-020 o_mdata_valid SHALL equal hold_valid; latency from wide transfer to narrow valid is exactly one cycle.
REQ-021 Selected slice SHALL be the lowest set bit of pending mask; o_mdata/o_mdata_byteen SHALL be that slice of the holding register.
REQ-022 On narrow transfer, the selected pending bit SHALL clear.
REQ-023 o_mdata_last SHALL equal held last AND pending mask has exactly one bit set.
REQ-024 o_mdata_accept SHALL equal !hold_valid OR (i_mdata_accept AND pending mask has exactly one bit set) -- back-to-back wide beats at full narrow throughput, no bubble.
REQ-025 Simultaneous final narrow transfer and wide transfer SHALL reload the holding register; hold_valid stays 1.
REQ-026 Final narrow transfer with no wide transfer SHALL clear hold_valid.
REQ-027 Holding contents SHALL not change while o_mdata_valid=1 and i_mdata_accept=0.
REQ-028 Data/byteen holding registers need no reset; control state SHALL be reset.

Reset
REQ-029 On i_rst_n low: hold_valid=0, pending mask=0, held last=0, immediately and independent of i_clk.
REQ-030 Reset outputs: o_mdata_valid=0, o_mdata_last=0, o_mdata_accept=1; o_mdata/o_mdata_byteen don't-care.
REQ-031 Reset asserted mid-beat SHALL discard remaining slices; first wide beat after release starts at slice selection anew.

Structure
REQ-032 RATIO and byte-enable width helpers SHALL be added to pzcorebus_pkg; slice-mask and lowest-set-bit logic stays local functions.
REQ-033 No sub-module; single flat module sitting upstream of the downsizer response path inside pzcorebus_downsizer.

Verification (SLAVE 128, MASTER 32, RATIO 4)
REQ-034 byteen=16'hFFFF, last=1, accept always 1 -> 4 narrow beats slice0..3, byteen 4'hF each, last only on beat 4, next wide accept same cycle as beat 4.
REQ-035 byteen=16'h0F00 -> single narrow beat, data=bits[95:64], byteen 4'hF; same with ALIGNED_ACCESS_ONLY=1 -> 4 beats, byteen 0,0,F,0.
REQ-036 byteen=16'h0000, last=1 -> one narrow beat from slice 3, byteen 4'h0, last=1.
REQ-037 Two wide beats back-to-back, narrow accept toggling 1,0,1,0 -> no data loss or reorder, output held stable while accept=0.
REQ-038 Reset asserted after 2 of 4 narrow beats -> valid drops immediately, accept=1; after release a new beat emits from slice 0.
